// File: rtl/rom_load_sequencer.sv
// ROM download router and core reset sequencer: filters data_io traffic by index, splits it into
// equal-size regions and holds the core in reset until a valid load. Option: ROM_LOAD_CHECKSUM_EN.
module rom_load_sequencer #(
  parameter int unsigned NUM_REGIONS    = 4,
  parameter int unsigned REGION_AW      = 14,
  parameter logic [7:0]  ROM_INDEX      = 8'd0,
  parameter int unsigned EXPECTED_BYTES = 65536,
  parameter int unsigned RESET_HOLD     = 1024
`ifdef ROM_LOAD_CHECKSUM_EN
  ,
  parameter logic [7:0]  EXPECTED_SUM   = 8'd0
`endif
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_downl,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic                   reset_req,
  output logic [NUM_REGIONS-1:0] region_we,
  output logic [REGION_AW-1:0]   region_addr,
  output logic [7:0]             region_data,
  output logic                   core_reset,
  output logic                   rom_loaded,
  output logic                   load_error,
  output logic [24:0]            bytes_loaded
`ifdef ROM_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]             checksum
`endif
);

  localparam int unsigned HoldW = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StLoading, StHold, StRun} state_e;

  state_e                 state_q, state_d;
  logic                   downl_q;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [24:0]            bytes_q, bytes_d;
  logic                   range_err_q, range_err_d;
  logic                   rom_loaded_q, rom_loaded_d;
  logic                   load_error_q, load_error_d;
  logic                   core_reset_q, core_reset_d;
  logic [NUM_REGIONS-1:0] region_we_q, region_we_d;
  logic [REGION_AW-1:0]   region_addr_q, region_addr_d;
  logic [7:0]             region_data_q, region_data_d;
  logic [7:0]             sum_q, sum_d;

  logic        dl_start, dl_end, start_load, wr_ok, in_range, load_ok;
  logic [24:0] region_sel, bytes_inc;

  assign dl_start   = ioctl_downl & ~downl_q & (ioctl_index == ROM_INDEX);
  assign dl_end     = ~ioctl_downl & downl_q;
  assign start_load = dl_start & (state_q != StLoading);
  assign wr_ok      = (state_q == StLoading) & ioctl_wr;
  assign region_sel = ioctl_addr >> REGION_AW;
  assign in_range   = region_sel < 25'(NUM_REGIONS);
  assign bytes_inc  = (bytes_q == '1) ? bytes_q : bytes_q + 25'd1;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    bytes_d       = bytes_q;
    range_err_d   = range_err_q;
    rom_loaded_d  = rom_loaded_q;
    load_error_d  = load_error_q;
    region_we_d   = '0;
    region_addr_d = region_addr_q;
    region_data_d = region_data_q;
    sum_d         = sum_q;

    // A write coincident with the end of load is folded in before the validity check.
    if (wr_ok) begin
      bytes_d = bytes_inc;
      sum_d   = sum_q + ioctl_dout;
      if (in_range) begin
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
          region_we_d[i] = (region_sel == 25'(i));
        end
        region_addr_d = ioctl_addr[REGION_AW-1:0];
        region_data_d = ioctl_dout;
      end else begin
        range_err_d = 1'b1;
      end
    end

`ifdef ROM_LOAD_CHECKSUM_EN
    load_ok = (bytes_d == 25'(EXPECTED_BYTES)) && !range_err_d && (sum_d == EXPECTED_SUM);
`else
    load_ok = (bytes_d == 25'(EXPECTED_BYTES)) && !range_err_d;
`endif

    if (start_load) begin
      state_d      = StLoading;
      bytes_d      = '0;
      rom_loaded_d = 1'b0;
      load_error_d = 1'b0;
      range_err_d  = 1'b0;
      sum_d        = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLoading: begin
          if (dl_end) begin
            if (load_ok) begin
              rom_loaded_d = 1'b1;
              hold_d       = HoldW'(RESET_HOLD);
              state_d      = StHold;
            end else begin
              load_error_d = 1'b1;
              state_d      = StIdle;
            end
          end
        end
        StHold: begin
          if (reset_req) begin
            hold_d = HoldW'(RESET_HOLD);
          end else if (hold_q <= HoldW'(1)) begin
            state_d = StRun;
          end else begin
            hold_d = hold_q - HoldW'(1);
          end
        end
        StRun: begin
          if (reset_req) begin
            hold_d  = HoldW'(RESET_HOLD);
            state_d = StHold;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    core_reset_d = (state_d != StRun);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      // Treat downl as already high so a download in flight across reset is not re-accepted.
      downl_q       <= 1'b1;
      hold_q        <= '0;
      bytes_q       <= '0;
      range_err_q   <= 1'b0;
      rom_loaded_q  <= 1'b0;
      load_error_q  <= 1'b0;
      core_reset_q  <= 1'b1;
      region_we_q   <= '0;
      region_addr_q <= '0;
      region_data_q <= '0;
      sum_q         <= '0;
    end else begin
      state_q       <= state_d;
      downl_q       <= ioctl_downl;
      hold_q        <= hold_d;
      bytes_q       <= bytes_d;
      range_err_q   <= range_err_d;
      rom_loaded_q  <= rom_loaded_d;
      load_error_q  <= load_error_d;
      core_reset_q  <= core_reset_d;
      region_we_q   <= region_we_d;
      region_addr_q <= region_addr_d;
      region_data_q <= region_data_d;
      sum_q         <= sum_d;
    end
  end

  assign region_we    = region_we_q;
  assign region_addr  = region_addr_q;
  assign region_data  = region_data_q;
  assign core_reset   = core_reset_q;
  assign rom_loaded   = rom_loaded_q;
  assign load_error   = load_error_q;
  assign bytes_loaded = bytes_q;
`ifdef ROM_LOAD_CHECKSUM_EN
  assign checksum     = sum_q;
`else
  logic unused_sum;
  assign unused_sum = ^sum_q;
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer with scaled-down regions (4 x 16 bytes, 64-byte image).
module tb_rom_load_sequencer;

  localparam int unsigned NR   = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned EXP  = 64;
  localparam int unsigned HOLD = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_downl;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          reset_req;
  logic [NR-1:0] region_we;
  logic [AW-1:0] region_addr;
  logic [7:0]    region_data;
  logic          core_reset;
  logic          rom_loaded;
  logic          load_error;
  logic [24:0]   bytes_loaded;
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  rom_load_sequencer #(
    .NUM_REGIONS   (NR),
    .REGION_AW     (AW),
    .ROM_INDEX     (8'd0),
    .EXPECTED_BYTES(EXP),
    .RESET_HOLD    (HOLD)
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    .EXPECTED_SUM  (8'h20)
`endif
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_index (ioctl_index),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .reset_req   (reset_req),
    .region_we   (region_we),
    .region_addr (region_addr),
    .region_data (region_data),
    .core_reset  (core_reset),
    .rom_loaded  (rom_loaded),
    .load_error  (load_error),
    .bytes_loaded(bytes_loaded)
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_downl = 1'b1;
    @(negedge clk_sys);
  endtask

  // One write, then the registered strobe the next cycle, then strobe gone.
  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input logic [NR-1:0] we);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check_eq("we", 32'(region_we), 32'(we));
    if (we != '0) begin
      check_eq("addr", 32'(region_addr), 32'(a[AW-1:0]));
      check_eq("data", 32'(region_data), 32'(d));
    end
    @(negedge clk_sys);
    check_eq("we_off", 32'(region_we), 32'h0);
  endtask

  // Data byte i is i+1, so a clean 64-byte image sums to 0x20 mod 256.
  task automatic do_load(input int nbytes, input int oor_at, input int bump_at, input bit coinc);
    logic [24:0]   a;
    logic [7:0]    d;
    logic [NR-1:0] we;
    start_dl(8'd0);
    for (int i = 0; i < nbytes; i++) begin
      a  = (i == oor_at) ? 25'h40 : 25'(i);
      d  = 8'(i + 1) + ((i == bump_at) ? 8'd1 : 8'd0);
      we = (i == oor_at) ? '0 : NR'(1 << (i / 16));
      if (coinc && i == nbytes - 1) begin
        @(negedge clk_sys);
        ioctl_downl = 1'b0;
        ioctl_wr    = 1'b1;
        ioctl_addr  = a;
        ioctl_dout  = d;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        check_eq("coinc_we", 32'(region_we), 32'(we));
        check_eq("coinc_data", 32'(region_data), 32'(d));
      end else begin
        write_byte(a, d, we);
      end
    end
    if (!coinc) begin
      @(negedge clk_sys);
      ioctl_downl = 1'b0;
      @(negedge clk_sys);
    end
    check_eq("bytes", 32'(bytes_loaded), 32'(nbytes));
  endtask

  // Called on the first sample after the end-of-load edge.
  task automatic check_hold(input string tag);
    int n = 0;
    while (core_reset === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    check_eq(tag, 32'(n), 32'(HOLD));
  endtask

  task automatic check_good(input string tag);
    check_eq({tag, "_loaded"}, 32'(rom_loaded), 32'h1);
    check_eq({tag, "_err"}, 32'(load_error), 32'h0);
    check_hold({tag, "_hold"});
    check_eq({tag, "_run"}, 32'(core_reset), 32'h0);
  endtask

  task automatic check_bad(input string tag);
    int bad = 0;
    check_eq({tag, "_loaded"}, 32'(rom_loaded), 32'h0);
    check_eq({tag, "_err"}, 32'(load_error), 32'h1);
    repeat (20) begin
      @(negedge clk_sys);
      if (core_reset !== 1'b1) bad++;
    end
    check_eq({tag, "_rst"}, 32'(bad), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int n;
    reset       = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    reset_req   = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_core", 32'(core_reset), 32'h1);
    check_eq("rst_we", 32'(region_we), 32'h0);
    check_eq("rst_bytes", 32'(bytes_loaded), 32'h0);
    check_eq("rst_loaded", 32'(rom_loaded), 32'h0);
    check_eq("rst_err", 32'(load_error), 32'h0);
    reset = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk_sys);
      if (core_reset !== 1'b1 || rom_loaded !== 1'b0 || region_we !== '0) bad++;
    end
    check_eq("idle", 32'(bad), 32'h0);

    do_load(64, -1, -1, 1'b0);
`ifdef ROM_LOAD_CHECKSUM_EN
    check_eq("sum_full", 32'(checksum), 32'h20);
`endif
    check_good("full");

    do_load(63, -1, -1, 1'b0);
    check_bad("short");
    do_load(64, -1, -1, 1'b0);
    check_good("reload");

    do_load(64, 5, -1, 1'b0);
    check_bad("range");

    do_load(64, -1, -1, 1'b0);
    check_good("pre_req");

    @(negedge clk_sys);
    reset_req = 1'b1;
    @(negedge clk_sys);
    check_eq("req_rise", 32'(core_reset), 32'h1);
    repeat (49) @(negedge clk_sys);
    reset_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (core_reset === 1'b1 && n < 200);
    check_eq("req_release", 32'(n), 32'(HOLD));

    start_dl(8'd1);
    write_byte(25'h3, 8'h77, '0);
    write_byte(25'h21, 8'h78, '0);
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_eq("idx1_core", 32'(core_reset), 32'h0);
    check_eq("idx1_bytes", 32'(bytes_loaded), 32'(EXP));
    check_eq("idx1_loaded", 32'(rom_loaded), 32'h1);

    do_load(64, -1, -1, 1'b1);
    check_good("coinc");

    do_load(64, -1, 10, 1'b0);
`ifdef ROM_LOAD_CHECKSUM_EN
    check_eq("sum_bump", 32'(checksum), 32'h21);
    check_bad("bump");
`else
    check_good("bump");
`endif

    start_dl(8'd0);
    write_byte(25'h0, 8'h11, NR'(1));
    write_byte(25'h1, 8'h12, NR'(1));
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check_eq("mid_bytes", 32'(bytes_loaded), 32'h0);
    check_eq("mid_core", 32'(core_reset), 32'h1);
    check_eq("mid_loaded", 32'(rom_loaded), 32'h0);
    write_byte(25'h2, 8'h13, '0);
    check_eq("mid_nocount", 32'(bytes_loaded), 32'h0);
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Parametrised ROM-download router and reset sequencer for arcade cores on clk_sys.
- Filters data_io download traffic by index and splits it into NUM_REGIONS equal-size ROM regions with registered write strobes.
- Checks the loaded byte count against the expected size and generates the core reset: held until a good load, then stretched on every reset request.
- Sits between data_io/user_io and the game core; it replaces ad-hoc "rom_loaded" logic in top-level wrappers.

Parameters:
- NUM_REGIONS, 4, number of ROM regions; each region is 2**REGION_AW bytes.
- REGION_AW, 14, address width of one region.
- ROM_INDEX, 0, ioctl_index value accepted as ROM download.
- EXPECTED_BYTES, 65536, exact byte count required for a valid load (≤ NUM_REGIONS*2**REGION_AW).
- RESET_HOLD, 1024, core_reset stretch length in clk_sys cycles (≥1).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_downl  in  1  download active (level).
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- reset_req  in  1  level request (OSD reset | button).
- region_we  out  NUM_REGIONS  one-hot registered write enable.
- region_addr  out  REGION_AW  registered offset within region.
- region_data  out  8  registered byte.
- core_reset  out  1  reset to game core.
- rom_loaded  out  1  last accepted load was valid.
- load_error  out  1  last accepted load failed.
- bytes_loaded  out  25  bytes counted in current/last load.

Behaviour:
- Async reset: state=IDLE, core_reset=1, rom_loaded=0, load_error=0, region_we=0, region_addr=0, region_data=0, bytes_loaded=0, hold counter=0.
- Download start = ioctl_downl registered low→high; accepted only if ioctl_index==ROM_INDEX at that edge. Other-index downloads are ignored entirely: no strobes, no state change, no counting.
- States:
  - IDLE: core_reset=1. Accepted start → LOADING.
  - LOADING: core_reset=1.
  - HOLD: core_reset=1, counter runs.
  - RUN: core_reset=0.
- Entering LOADING (from IDLE, HOLD or RUN): clear bytes_loaded, rom_loaded, load_error, and the internal range-error flag.
- LOADING, per ioctl_wr:
  - bytes_loaded += 1 (saturates at all-ones).
  - region = ioctl_addr >> REGION_AW.
  - If region < NUM_REGIONS: next cycle region_we[region]=1 for exactly one cycle, with region_addr=ioctl_addr[REGION_AW-1:0] and region_data=ioctl_dout.
  - Else: no strobe; set range-error flag.
  - Write latency: 1 cycle.
- End of load = ioctl_downl high→low, observed while in LOADING. A ioctl_wr in the same cycle is counted first, using the post-increment count.
  - Count==EXPECTED_BYTES and no range error: rom_loaded=1; go to HOLD with counter=RESET_HOLD.
  - Otherwise: load_error=1; go to IDLE.
- HOLD: counter decrements each cycle; at 1 → RUN. If reset_req is high, the counter reloads to RESET_HOLD, so core_reset is released exactly RESET_HOLD cycles after reset_req falls.
- RUN: reset_req high → HOLD with counter=RESET_HOLD.
- reset_req in IDLE or LOADING has no effect (core_reset is already 1).
- Async reset mid-load: all state cleared; the partial load is discarded and a new download is required.
- region_we is never asserted outside LOADING or for more than one bit at a time.

Optional Feature:
- Macro ROM_LOAD_CHECKSUM_EN.
- Defined:
  - Extra parameter EXPECTED_SUM (8-bit, default 0).
  - Extra output checksum[7:0]: modulo-256 sum of all accepted bytes, including out-of-range ones. Cleared on LOADING entry and on reset.
  - The valid-load condition additionally requires checksum==EXPECTED_SUM at end of load; on mismatch, load_error=1 and go to IDLE.
- Undefined: no checksum port or logic; validity is count and range only.

Test Plan:
- Reset then idle 100 cycles → core_reset=1, rom_loaded=0, region_we=0 throughout.
- NUM_REGIONS=4, REGION_AW=14, EXPECTED_BYTES=65536; download index 0 with addresses 0..65535 → region_we[0..3] each pulse 16384 times, one cycle after each ioctl_wr, with region_addr=addr[13:0]. After downl falls: rom_loaded=1, core_reset=1 for 1024 cycles, then 0.
- Same download truncated to 65535 bytes → load_error=1, rom_loaded=0, core_reset stays 1. A following full download → rom_loaded=1, load_error=0.
- Download containing a write at address 0x10000 → no region_we for it, load_error=1 at end even if total count==65536.
- In RUN, reset_req high for 50 cycles → core_reset rises the next cycle and falls exactly 1024 cycles after reset_req falls. A download with index 1 in RUN → no strobes, core_reset stays 0.
- Last ioctl_wr coincident with downl falling → counted, load valid. With ROM_LOAD_CHECKSUM_EN and EXPECTED_SUM mismatched by 1 → load_error=1.
